// File: rtl/sseg_scan_ctrl_if.sv
// Value-load handshake between a display producer and the 7-segment scan controller.
// The producer offers a full set of hex nibbles plus decimal points in one transfer.
interface sseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 6
);

  logic                    value_valid;
  logic                    value_ready;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;

  modport master (
    output value_valid,
    output value,
    output dp_mask,
    input  value_ready
  );

  modport slave (
    input  value_valid,
    input  value,
    input  dp_mask,
    output value_ready
  );

endinterface

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
// New values wait in a one-deep pending slot and are swapped in only at frame boundaries.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS    = 6,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sseg_scan_ctrl_if.slave       bus,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  dec_en,
  output logic [3:0]            dec_hex,
  output logic                  dec_dp,
  output logic                  frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // XOR mask that turns an active-high one-hot strobe into the pin polarity
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {
    PEND_EMPTY,
    PEND_FULL
  } pend_state_t;

  pend_state_t pend_state;
  pend_state_t pend_next;

  logic [CW-1:0]              slot_cnt;
  logic [IW-1:0]              digit_idx;
  logic [4*NUM_DIGITS-1:0]    disp_val;
  logic [NUM_DIGITS-1:0]      disp_dp;
  logic [4*NUM_DIGITS-1:0]    pend_val;
  logic [NUM_DIGITS-1:0]      pend_dp;

  logic                       slot_wrap;
  logic                       frame_wrap;
  logic                       accept;
  logic                       swap;
  logic                       in_gap;
  logic                       zero_run;
  logic                       cur_blank;
  logic                       cur_dp;
  logic [3:0]                 cur_nib;
  logic [NUM_DIGITS-1:0]      sel_act;

  assign slot_wrap  = (slot_cnt == CW'(REFRESH_DIV - 1));
  assign frame_wrap = slot_wrap && (digit_idx == IW'(NUM_DIGITS - 1));
  assign accept     = bus.value_valid && bus.value_ready;
  assign in_gap     = (slot_cnt < CW'(BLANK_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_state <= PEND_EMPTY;
    end else begin
      pend_state <= pend_next;
    end
  end

  // Accept and swap are mutually exclusive: accept needs the slot empty, swap needs it full
  always_comb begin
    pend_next = pend_state;
    swap      = 1'b0;
    case (pend_state)
      PEND_EMPTY: begin
        if (accept) begin
          pend_next = PEND_FULL;
        end
      end
      PEND_FULL: begin
        if (frame_wrap) begin
          swap      = 1'b1;
          pend_next = PEND_EMPTY;
        end
      end
      default: pend_next = PEND_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      if (slot_wrap) begin
        slot_cnt <= '0;
        if (digit_idx == IW'(NUM_DIGITS - 1)) begin
          digit_idx <= '0;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (accept) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_mask;
      end
      if (swap) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
    end
  end

  // Walk digits from the top down so zero_run holds "everything from k upward is blank-able"
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_act   = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (k > 0) begin
        zero_run = zero_run && (disp_val[4*k +: 4] == 4'h0) && !disp_dp[k];
      end
      if (digit_idx == IW'(k)) begin
        cur_nib    = disp_val[4*k +: 4];
        cur_dp     = disp_dp[k];
        cur_blank  = blank_lz && (k > 0) && zero_run;
        sel_act[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit_sel       <= SEL_OFF;
      dec_en          <= 1'b0;
      dec_hex         <= 4'h0;
      dec_dp          <= 1'b1;
      frame_done      <= 1'b0;
      bus.value_ready <= 1'b0;
    end else begin
      frame_done      <= frame_wrap;
      bus.value_ready <= (pend_next == PEND_EMPTY);
      if (in_gap) begin
        digit_sel <= SEL_OFF;
        dec_en    <= 1'b0;
        dec_hex   <= 4'h0;
        dec_dp    <= 1'b1;
      end else begin
        digit_sel <= cur_blank ? SEL_OFF : (sel_act ^ SEL_OFF);
        dec_en    <= !cur_blank;
        dec_hex   <= cur_nib;
        dec_dp    <= !cur_dp;
      end
    end
  end

endmodule
